// File: rtl/branch_recovery_ctrl.sv
// Branch recovery controller: turns a one-cycle taken resolution into flush -> rename-restore wait -> fetch redirect.
// Latency: input to OUT_flush is 1 cycle; input to OUT_if_valid is at least FLUSH_CYCLES+2 cycles.
// Backpressure: the redirect holds valid/pc until IN_if_ready; only a newly captured resolution can withdraw it.
//
// Ports:
//   clk, rst (async active-low)         clock / reset
//   IN_br_*                             winning branch resolution (taken, flush, sqN, dstPC)
//   IN_rn_restoreDone                   rename-map restore acknowledge pulse
//   IN_if_ready                         fetch accepts the redirect
//   OUT_flush/OUT_flushAll/OUT_flushSqN backend squash request
//   OUT_rnStall, OUT_busy               recovery in progress
//   OUT_if_valid, OUT_if_pc             fetch redirect request
// Optional: define BRANCH_RECOVERY_PERF_EN to add OUT_PERFC_recoveries / OUT_PERFC_stallCycles.
module branch_recovery_ctrl #(
  parameter int SQN_W        = 7,
  parameter int PC_W         = 31,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_br_taken,
  input  logic             IN_br_flush,
  input  logic [SQN_W-1:0] IN_br_sqN,
  input  logic [PC_W-1:0]  IN_br_dstPC,
  input  logic             IN_rn_restoreDone,
  input  logic             IN_if_ready,
  output logic             OUT_flush,
  output logic             OUT_flushAll,
  output logic [SQN_W-1:0] OUT_flushSqN,
  output logic             OUT_rnStall,
  output logic             OUT_if_valid,
  output logic [PC_W-1:0]  OUT_if_pc,
  output logic             OUT_busy
`ifdef BRANCH_RECOVERY_PERF_EN
  ,
  output logic [31:0]      OUT_PERFC_recoveries,
  output logic [31:0]      OUT_PERFC_stallCycles
`endif
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    WAIT_RN  = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rn_seen, w_rn_seen_nxt;
  logic [SQN_W-1:0] r_pend_sqn;
  logic [PC_W-1:0]  r_pend_pc;
  logic             r_pend_all;

  logic [SQN_W-1:0] w_sqn_diff;
  logic             w_older;
  logic             w_capture;

  // Age compare is a wrap-safe signed difference: negative means the input is older.
  assign w_sqn_diff = IN_br_sqN - r_pend_sqn;
  assign w_older    = w_sqn_diff[SQN_W-1];

  // Once a full flush is pending, only another full flush may replace it.
  assign w_capture = IN_br_taken &&
                     ((r_state == IDLE) || IN_br_flush || (w_older && !r_pend_all));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rn_seen_nxt = r_rn_seen;
    if (w_capture) begin
      // Capture beats everything, including a same-cycle redirect handshake.
      w_state_nxt   = FLUSH;
      w_cnt_nxt     = CNT_W'(FLUSH_CYCLES - 1);
      w_rn_seen_nxt = 1'b0;
    end else begin
      case (r_state)
        FLUSH: begin
          // An early restore acknowledge is remembered so WAIT_RN can leave immediately.
          if (IN_rn_restoreDone) w_rn_seen_nxt = 1'b1;
          if (r_cnt == '0) w_state_nxt = WAIT_RN;
          else             w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        WAIT_RN: begin
          if (IN_rn_restoreDone || r_rn_seen) begin
            w_state_nxt   = REDIRECT;
            w_rn_seen_nxt = 1'b0;
          end
        end
        REDIRECT: begin
          if (IN_if_ready) w_state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rn_seen  <= 1'b0;
      r_pend_sqn <= '0;
      r_pend_pc  <= '0;
      r_pend_all <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rn_seen <= w_rn_seen_nxt;
      if (w_capture) begin
        r_pend_sqn <= IN_br_sqN;
        r_pend_pc  <= IN_br_dstPC;
        r_pend_all <= IN_br_flush;
      end
    end
  end

  // Outputs decode only flops, so there is no combinational input-to-output path.
  assign OUT_flush    = (r_state == FLUSH);
  assign OUT_flushAll = (r_state == FLUSH) && r_pend_all;
  assign OUT_flushSqN = (r_state == FLUSH) ? r_pend_sqn : '0;
  assign OUT_if_valid = (r_state == REDIRECT);
  assign OUT_if_pc    = (r_state == REDIRECT) ? r_pend_pc : '0;
  assign OUT_busy     = (r_state != IDLE);
  assign OUT_rnStall  = OUT_busy;

`ifdef BRANCH_RECOVERY_PERF_EN
  logic [31:0] r_perf_rec;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_rec   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_capture && (r_state == IDLE) && (r_perf_rec != '1))
        r_perf_rec <= r_perf_rec + 32'd1;
      if ((r_state != IDLE) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign OUT_PERFC_recoveries  = r_perf_rec;
  assign OUT_PERFC_stallCycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
module tb_branch_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        IN_br_taken = 1'b0;
  logic        IN_br_flush = 1'b0;
  logic [6:0]  IN_br_sqN = '0;
  logic [30:0] IN_br_dstPC = '0;
  logic        IN_rn_restoreDone = 1'b0;
  logic        IN_if_ready = 1'b0;
  logic        OUT_flush, OUT_flushAll, OUT_rnStall, OUT_if_valid, OUT_busy;
  logic [6:0]  OUT_flushSqN;
  logic [30:0] OUT_if_pc;
`ifdef BRANCH_RECOVERY_PERF_EN
  logic [31:0] OUT_PERFC_recoveries, OUT_PERFC_stallCycles;
`endif

  int errors = 0;
  int checks = 0;

  branch_recovery_ctrl #(.SQN_W(7), .PC_W(31), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .IN_br_taken(IN_br_taken), .IN_br_flush(IN_br_flush),
    .IN_br_sqN(IN_br_sqN), .IN_br_dstPC(IN_br_dstPC),
    .IN_rn_restoreDone(IN_rn_restoreDone), .IN_if_ready(IN_if_ready),
    .OUT_flush(OUT_flush), .OUT_flushAll(OUT_flushAll), .OUT_flushSqN(OUT_flushSqN),
    .OUT_rnStall(OUT_rnStall), .OUT_if_valid(OUT_if_valid), .OUT_if_pc(OUT_if_pc),
    .OUT_busy(OUT_busy)
`ifdef BRANCH_RECOVERY_PERF_EN
    , .OUT_PERFC_recoveries(OUT_PERFC_recoveries), .OUT_PERFC_stallCycles(OUT_PERFC_stallCycles)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic fl, input logic [6:0] s, input logic [30:0] pc);
    IN_br_taken = 1'b1;
    IN_br_flush = fl;
    IN_br_sqN   = s;
    IN_br_dstPC = pc;
  endtask

  task automatic clear_br();
    IN_br_taken = 1'b0;
    IN_br_flush = 1'b0;
  endtask

  // Finish any recovery in progress: acknowledge restore, accept redirect, bounded wait for IDLE.
  task automatic drain();
    int n;
    n = 0;
    IN_if_ready = 1'b1;
    while (OUT_busy === 1'b1 && n < 20) begin
      IN_rn_restoreDone = 1'b1;
      tick();
      n++;
    end
    IN_rn_restoreDone = 1'b0;
    checks++;
    if (OUT_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout busy=%b required 0", OUT_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({OUT_flush, OUT_flushAll, OUT_flushSqN, OUT_rnStall, OUT_if_valid, OUT_if_pc, OUT_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs flush=%b all=%b sqn=%h stall=%b vld=%b pc=%h busy=%b required all 0",
               OUT_flush, OUT_flushAll, OUT_flushSqN, OUT_rnStall, OUT_if_valid, OUT_if_pc, OUT_busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (OUT_busy !== 1'b0) begin errors++; $display("FAIL reset_release busy=%b required 0", OUT_busy); end
  endtask

  task automatic test_single();
    IN_if_ready = 1'b1;
    drive_br(1'b0, 7'd5, 31'h100);
    tick(); clear_br();
    checks++;
    if (OUT_flush !== 1'b1 || OUT_flushSqN !== 7'd5 || OUT_flushAll !== 1'b0) begin
      errors++; $display("FAIL single_c1_flush flush=%b sqn=%0d all=%b required 1/5/0", OUT_flush, OUT_flushSqN, OUT_flushAll);
    end
    checks++;
    if (OUT_busy !== 1'b1 || OUT_rnStall !== 1'b1 || OUT_if_valid !== 1'b0) begin
      errors++; $display("FAIL single_c1_busy busy=%b stall=%b vld=%b required 1/1/0", OUT_busy, OUT_rnStall, OUT_if_valid);
    end
    tick();
    checks++;
    if (OUT_flush !== 1'b1 || OUT_flushSqN !== 7'd5) begin
      errors++; $display("FAIL single_c2_flush flush=%b sqn=%0d required 1/5", OUT_flush, OUT_flushSqN);
    end
    tick();
    checks++;
    if (OUT_flush !== 1'b0 || OUT_busy !== 1'b1 || OUT_if_valid !== 1'b0) begin
      errors++; $display("FAIL single_c3_wait flush=%b busy=%b vld=%b required 0/1/0", OUT_flush, OUT_busy, OUT_if_valid);
    end
    tick();
    checks++;
    if (OUT_if_valid !== 1'b0 || OUT_busy !== 1'b1) begin
      errors++; $display("FAIL single_c4_wait vld=%b busy=%b required 0/1", OUT_if_valid, OUT_busy);
    end
    IN_rn_restoreDone = 1'b1;
    tick();
    IN_rn_restoreDone = 1'b0;
    checks++;
    if (OUT_if_valid !== 1'b1 || OUT_if_pc !== 31'h100) begin
      errors++; $display("FAIL single_c5_redirect vld=%b pc=%h required 1/100", OUT_if_valid, OUT_if_pc);
    end
    tick();
    checks++;
    if (OUT_if_valid !== 1'b0 || OUT_busy !== 1'b0) begin
      errors++; $display("FAIL single_c6_idle vld=%b busy=%b required 0/0", OUT_if_valid, OUT_busy);
    end
`ifdef BRANCH_RECOVERY_PERF_EN
    checks++;
    if (OUT_PERFC_recoveries !== 32'd1 || OUT_PERFC_stallCycles !== 32'd5) begin
      errors++; $display("FAIL perf_single rec=%0d stall=%0d required 1/5", OUT_PERFC_recoveries, OUT_PERFC_stallCycles);
    end
`endif
  endtask

  task automatic test_older_restart();
    drive_br(1'b0, 7'd10, 31'h10);
    tick(); clear_br();
    drive_br(1'b0, 7'd8, 31'h20);
    tick(); clear_br();
    checks++;
    if (OUT_flush !== 1'b1 || OUT_flushSqN !== 7'd8) begin
      errors++; $display("FAIL older_capture flush=%b sqn=%0d required 1/8", OUT_flush, OUT_flushSqN);
    end
    tick();
    checks++;
    if (OUT_flush !== 1'b1 || OUT_flushSqN !== 7'd8) begin
      errors++; $display("FAIL older_counter_restart flush=%b sqn=%0d required 1/8", OUT_flush, OUT_flushSqN);
    end
    tick();
    checks++;
    if (OUT_flush !== 1'b0) begin errors++; $display("FAIL older_flush_end flush=%b required 0", OUT_flush); end
    drain();
    checks++;
    if (OUT_if_pc !== 31'h0) begin errors++; $display("FAIL older_idle_pc pc=%h required 0", OUT_if_pc); end
  endtask

  task automatic test_younger_ignored();
    drive_br(1'b0, 7'd10, 31'h10);
    tick(); clear_br();
    drive_br(1'b0, 7'd12, 31'h30);
    tick(); clear_br();
    checks++;
    if (OUT_flush !== 1'b1 || OUT_flushSqN !== 7'd10) begin
      errors++; $display("FAIL younger_retained flush=%b sqn=%0d required 1/10", OUT_flush, OUT_flushSqN);
    end
    tick();
    checks++;
    if (OUT_flush !== 1'b0) begin errors++; $display("FAIL younger_no_restart flush=%b required 0", OUT_flush); end
    drain();
  endtask

  task automatic test_wrap();
    drive_br(1'b0, 7'h7E, 31'h40);
    tick(); clear_br();
    drive_br(1'b0, 7'h02, 31'h50);
    tick(); clear_br();
    checks++;
    if (OUT_flushSqN !== 7'h7E) begin errors++; $display("FAIL wrap_younger sqn=%h required 7e", OUT_flushSqN); end
    tick();
    checks++;
    if (OUT_flush !== 1'b0) begin errors++; $display("FAIL wrap_younger_no_restart flush=%b required 0", OUT_flush); end
    drain();
    // Reverse direction: 0x7E is older than pending 0x02 across the wrap.
    drive_br(1'b0, 7'h02, 31'h60);
    tick(); clear_br();
    drive_br(1'b0, 7'h7E, 31'h70);
    tick(); clear_br();
    checks++;
    if (OUT_flush !== 1'b1 || OUT_flushSqN !== 7'h7E) begin
      errors++; $display("FAIL wrap_older flush=%b sqn=%h required 1/7e", OUT_flush, OUT_flushSqN);
    end
    drain();
  endtask

  task automatic test_rd_idle_ignored();
    IN_if_ready = 1'b1;
    IN_rn_restoreDone = 1'b1;
    tick();
    IN_rn_restoreDone = 1'b0;
    drive_br(1'b0, 7'd20, 31'h80);
    tick(); clear_br();
    tick(); tick(); tick();
    checks++;
    if (OUT_if_valid !== 1'b0 || OUT_busy !== 1'b1) begin
      errors++; $display("FAIL rd_idle_ignored vld=%b busy=%b required 0/1", OUT_if_valid, OUT_busy);
    end
    drain();
  endtask

  task automatic test_early_restore();
    IN_if_ready = 1'b1;
    drive_br(1'b0, 7'd30, 31'h90);
    tick(); clear_br();
    IN_rn_restoreDone = 1'b1;
    tick();
    IN_rn_restoreDone = 1'b0;
    tick();
    checks++;
    if (OUT_if_valid !== 1'b0 || OUT_busy !== 1'b1) begin
      errors++; $display("FAIL early_c3 vld=%b busy=%b required 0/1", OUT_if_valid, OUT_busy);
    end
    tick();
    checks++;
    if (OUT_if_valid !== 1'b1 || OUT_if_pc !== 31'h90) begin
      errors++; $display("FAIL early_c4_redirect vld=%b pc=%h required 1/90", OUT_if_valid, OUT_if_pc);
    end
    tick();
    checks++;
    if (OUT_busy !== 1'b0) begin errors++; $display("FAIL early_idle busy=%b required 0", OUT_busy); end
  endtask

  task automatic test_ready_hold();
    IN_if_ready = 1'b0;
    drive_br(1'b0, 7'd40, 31'h2222);
    tick(); clear_br();
    tick(); tick();
    IN_rn_restoreDone = 1'b1;
    tick();
    IN_rn_restoreDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (OUT_if_valid !== 1'b1 || OUT_if_pc !== 31'h2222) begin
        errors++; $display("FAIL ready_hold_%0d vld=%b pc=%h required 1/2222", i, OUT_if_valid, OUT_if_pc);
      end
      tick();
    end
    checks++;
    if (OUT_if_valid !== 1'b1) begin errors++; $display("FAIL ready_hold_pre_hs vld=%b required 1", OUT_if_valid); end
    IN_if_ready = 1'b1;
    tick();
    checks++;
    if (OUT_if_valid !== 1'b0 || OUT_busy !== 1'b0) begin
      errors++; $display("FAIL ready_hold_idle vld=%b busy=%b required 0/0", OUT_if_valid, OUT_busy);
    end
  endtask

  task automatic test_flushall_in_redirect();
    IN_if_ready = 1'b0;
    drive_br(1'b0, 7'd60, 31'h300);
    tick(); clear_br();
    tick(); tick();
    IN_rn_restoreDone = 1'b1;
    tick();
    IN_rn_restoreDone = 1'b0;
    checks++;
    if (OUT_if_valid !== 1'b1 || OUT_if_pc !== 31'h300) begin
      errors++; $display("FAIL fa_redirect vld=%b pc=%h required 1/300", OUT_if_valid, OUT_if_pc);
    end
    // Same-cycle handshake and capture: capture wins.
    IN_if_ready = 1'b1;
    drive_br(1'b1, 7'd70, 31'h400);
    tick(); clear_br();
    checks++;
    if (OUT_if_valid !== 1'b0 || OUT_flush !== 1'b1 || OUT_flushAll !== 1'b1 || OUT_flushSqN !== 7'd70) begin
      errors++; $display("FAIL fa_capture vld=%b flush=%b all=%b sqn=%0d required 0/1/1/70",
                         OUT_if_valid, OUT_flush, OUT_flushAll, OUT_flushSqN);
    end
    drive_br(1'b0, 7'd65, 31'h500);
    tick(); clear_br();
    checks++;
    if (OUT_flushAll !== 1'b1 || OUT_flushSqN !== 7'd70) begin
      errors++; $display("FAIL fa_drop_older all=%b sqn=%0d required 1/70", OUT_flushAll, OUT_flushSqN);
    end
    tick();
    checks++;
    if (OUT_flush !== 1'b0 || OUT_busy !== 1'b1) begin
      errors++; $display("FAIL fa_no_restart flush=%b busy=%b required 0/1", OUT_flush, OUT_busy);
    end
    IN_rn_restoreDone = 1'b1;
    tick();
    IN_rn_restoreDone = 1'b0;
    checks++;
    if (OUT_if_valid !== 1'b1 || OUT_if_pc !== 31'h400) begin
      errors++; $display("FAIL fa_final_redirect vld=%b pc=%h required 1/400", OUT_if_valid, OUT_if_pc);
    end
    tick();
    checks++;
    if (OUT_busy !== 1'b0) begin errors++; $display("FAIL fa_idle busy=%b required 0", OUT_busy); end
  endtask

  task automatic test_reset_mid();
    IN_if_ready = 1'b1;
    drive_br(1'b0, 7'd80, 31'h600);
    tick(); clear_br();
    tick(); tick();
    checks++;
    if (OUT_busy !== 1'b1 || OUT_flush !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_wait busy=%b flush=%b required 1/0", OUT_busy, OUT_flush);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({OUT_flush, OUT_flushAll, OUT_flushSqN, OUT_rnStall, OUT_if_valid, OUT_if_pc, OUT_busy} !== '0) begin
      errors++; $display("FAIL rstmid_async busy=%b stall=%b vld=%b required all 0", OUT_busy, OUT_rnStall, OUT_if_valid);
    end
`ifdef BRANCH_RECOVERY_PERF_EN
    checks++;
    if (OUT_PERFC_recoveries !== 32'd0 || OUT_PERFC_stallCycles !== 32'd0) begin
      errors++; $display("FAIL perf_reset rec=%0d stall=%0d required 0/0", OUT_PERFC_recoveries, OUT_PERFC_stallCycles);
    end
`endif
    tick();
    rst = 1'b1;
    IN_rn_restoreDone = 1'b1;
    tick();
    IN_rn_restoreDone = 1'b0;
    tick();
    checks++;
    if (OUT_if_valid !== 1'b0 || OUT_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_replay vld=%b busy=%b required 0/0", OUT_if_valid, OUT_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_older_restart();
    test_younger_ignored();
    test_wrap();
    test_rd_idle_ignored();
    test_early_restore();
    test_ready_hold();
    test_flushall_in_redirect();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
